axis_traffic_gen: RTL
=====================

AXIS_TRAFFIC_GEN -- requirements
Module: axis_traffic_gen

Interface
REQ-001 SHALL have parameter TID_WIDTH, default 2, AXIS tid width.
REQ-002 SHALL have parameter TDEST_WIDTH, default 4, AXIS tdest width.
REQ-003 SHALL have parameter TDATA_WIDTH, default 512, beat width; must be a multiple of 32.
REQ-004 SHALL have parameter SRC_ID, default 0, 8-bit source node id stamped in payload.
REQ-005 SHALL have parameter NUM_NODES, default 16, destination wrap modulus.
REQ-006 SHALL have parameter MAX_PKT_LEN, default 16, maximum beats per packet, range 1..255.
REQ-007 SHALL have parameter GAP_CYCLES, default 2, inter-packet idle cycles; used only under AXIS_TGEN_GAP_EN.
REQ-008 SHALL provide clk_usr input 1: sole clock, all logic on its rising edge.
REQ-009 SHALL provide rst_usr_sync input 1: reset, synchronous and active-high.
REQ-010 SHALL provide: start input 1 (launch pulse); num_packets input 16; pkt_len input 8 (beats per packet); dest_incr input 1 (0 fixed, 1 incrementing); base_dest input TDEST_WIDTH.
REQ-011 SHALL provide: busy output 1; done output 1 (one-cycle pulse); pkts_sent output 16.
REQ-012 SHALL provide AXIS master: axis_out_tvalid output 1, axis_out_tready input 1, axis_out_tdata output TDATA_WIDTH, axis_out_tlast output 1, axis_out_tid output TID_WIDTH, axis_out_tdest output TDEST_WIDTH.

Function
REQ-013 SHALL implement FSM states IDLE, SEND, GAP (macro only), DONE.
REQ-014 In IDLE, start=1 SHALL capture num_packets, clamped pkt_len (0->1, >MAX_PKT_LEN->MAX_PKT_LEN), dest_incr, base_dest; clear pkts_sent; go to SEND next cycle, or to DONE if num_packets=0.
REQ-015 start outside IDLE SHALL be ignored; config inputs SHALL be sampled only at accepted start.
REQ-016 In SEND, axis_out_tvalid SHALL be 1; a beat transfers on tvalid&&tready.
REQ-017 Once tvalid is high, tdata/tlast/tid/tdest SHALL stay stable until the transfer; tvalid SHALL NOT drop without a transfer.
REQ-018 tdata SHALL be TDATA_WIDTH/32 copies of the 32-bit word {pkt_seq[15:0], beat_idx[7:0], SRC_ID[7:0]}, MSB first.
REQ-019 axis_out_tlast SHALL be 1 exactly when beat_idx = captured_len-1.
REQ-020 axis_out_tid SHALL equal pkt_seq[TID_WIDTH-1:0].
REQ-021 axis_out_tdest SHALL be base_dest when dest_incr=0; else (base_dest+pkt_seq) mod NUM_NODES, constant within a packet.
REQ-022 On the last-beat transfer: beat_idx->0, pkt_seq and pkts_sent +1; if pkts_sent reaches captured num_packets go to DONE, else next packet (SEND, or GAP under macro).
REQ-023 First beat SHALL appear the cycle after accepted start; throughput one beat per cycle when tready=1.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE; busy=1 in SEND, GAP, DONE.
REQ-025 pkts_sent SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-026 rst_usr_sync=1 SHALL force IDLE and tvalid=0, tlast=0, tdata=0, tid=0, tdest=0, busy=0, done=0, pkts_sent=0, counters 0.
REQ-027 Reset mid-packet SHALL abort immediately; no further beats until a new start after reset release.

Configuration
REQ-028 With AXIS_TGEN_GAP_EN defined, after each non-final packet the block SHALL enter GAP with tvalid=0 for GAP_CYCLES cycles (GAP_CYCLES=0 -> GAP skipped).
REQ-029 Without AXIS_TGEN_GAP_EN, the next packet's first beat SHALL be valid the cycle after the previous last-beat transfer; GAP state absent.

Verification
REQ-030 num_packets=2, pkt_len=4, dest_incr=0, base_dest=5, tready=1 -> 8 contiguous beats, tlast on beats 3 and 7, tdest=5, tid 0 then 1, done pulse cycle after beat 7, pkts_sent=2.
REQ-031 num_packets=3, pkt_len=1, dest_incr=1, base_dest=15, NUM_NODES=16 -> three single-beat packets, tdest 15,0,1, tlast=1 on every beat.
REQ-032 tready toggling 1,0,0,1 during a packet -> tvalid held, payload unchanged across stall cycles, no beat lost or duplicated.
REQ-033 num_packets=0 -> no tvalid, done one cycle after start; pkt_len=0 -> 1-beat packets; pkt_len=200, MAX_PKT_LEN=16 -> 16-beat packets.
REQ-034 rst_usr_sync asserted on beat 2 of 4 -> tvalid=0 next cycle, pkts_sent=0; start during SEND ignored.
REQ-035 AXIS_TGEN_GAP_EN, GAP_CYCLES=2, two 2-beat packets, tready=1 -> exactly 2 tvalid=0 cycles between packets; without macro, 0.

Source files
------------

// File: rtl/axis_traffic_gen.sv
// AXI-Stream packet generator: bursts of counted packets with a stamped, self-describing payload.
// Optional inter-packet idle gap is enabled by defining AXIS_TGEN_GAP_EN.
module axis_traffic_gen #(
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int SRC_ID      = 0,
  parameter int NUM_NODES   = 16,
  parameter int MAX_PKT_LEN = 16,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                   clk_usr,
  input  logic                   rst_usr_sync,
  input  logic                   start,
  input  logic [15:0]            num_packets,
  input  logic [7:0]             pkt_len,
  input  logic                   dest_incr,
  input  logic [TDEST_WIDTH-1:0] base_dest,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            pkts_sent,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0] axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TID_WIDTH-1:0]   axis_out_tid,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest
);

  localparam int          WORDS     = TDATA_WIDTH / 32;
  localparam logic [7:0]  MAX_LEN_L = 8'(MAX_PKT_LEN);
  localparam logic [31:0] NODES_L   = 32'(NUM_NODES);

`ifdef AXIS_TGEN_GAP_EN
  localparam logic [15:0] GAP_L = 16'(GAP_CYCLES);
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  logic [15:0] gap_cnt_q;
`else
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif

  state_t                 state, state_nxt;
  logic [15:0]            num_pkts_q, pkt_seq_q, pkts_sent_q;
  logic [7:0]             len_q, beat_idx_q;
  logic                   dest_incr_q;
  logic [TDEST_WIDTH-1:0] base_dest_q;
  logic                   xfer, last_beat, pkt_end, final_pkt;
  logic [7:0]             len_clamped;
  logic [31:0]            dest_sum;
  logic [TDEST_WIDTH-1:0] dest_calc;
  logic [31:0]            word;

  assign xfer      = (state == SEND) && axis_out_tready;
  assign last_beat = (beat_idx_q == len_q - 8'd1);
  assign pkt_end   = xfer && last_beat;
  assign final_pkt = ((pkts_sent_q + 16'd1) == num_pkts_q);

  always_comb begin
    len_clamped = pkt_len;
    if (pkt_len == 8'd0)            len_clamped = 8'd1;
    else if (pkt_len > MAX_LEN_L)   len_clamped = MAX_LEN_L;
  end

  always_ff @(posedge clk_usr) begin
    if (rst_usr_sync) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (num_packets == 16'd0) ? DONE : SEND;
      SEND: if (pkt_end) begin
        if (final_pkt) state_nxt = DONE;
`ifdef AXIS_TGEN_GAP_EN
        else           state_nxt = (GAP_CYCLES == 0) ? SEND : GAP;
`else
        else           state_nxt = SEND;
`endif
      end
`ifdef AXIS_TGEN_GAP_EN
      GAP:  if (gap_cnt_q == GAP_L - 16'd1) state_nxt = SEND;
`endif
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Packet/beat counters only move on an accepted start or a completed transfer,
  // which keeps the payload stable while the sink stalls.
  always_ff @(posedge clk_usr) begin
    if (rst_usr_sync) begin
      num_pkts_q  <= '0;
      pkt_seq_q   <= '0;
      pkts_sent_q <= '0;
      len_q       <= '0;
      beat_idx_q  <= '0;
      dest_incr_q <= 1'b0;
      base_dest_q <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        num_pkts_q  <= num_packets;
        len_q       <= len_clamped;
        dest_incr_q <= dest_incr;
        base_dest_q <= base_dest;
        pkt_seq_q   <= '0;
        pkts_sent_q <= '0;
        beat_idx_q  <= '0;
      end
    end else if (xfer) begin
      if (last_beat) begin
        beat_idx_q  <= '0;
        pkt_seq_q   <= pkt_seq_q + 16'd1;
        pkts_sent_q <= pkts_sent_q + 16'd1;
      end else begin
        beat_idx_q  <= beat_idx_q + 8'd1;
      end
    end
  end

`ifdef AXIS_TGEN_GAP_EN
  always_ff @(posedge clk_usr) begin
    if (rst_usr_sync || state != GAP) gap_cnt_q <= '0;
    else                              gap_cnt_q <= gap_cnt_q + 16'd1;
  end
`endif

  assign dest_sum  = 32'(base_dest_q) + 32'(pkt_seq_q);
  assign dest_calc = dest_incr_q ? TDEST_WIDTH'(dest_sum % NODES_L) : base_dest_q;
  assign word      = {pkt_seq_q, beat_idx_q, 8'(SRC_ID)};

  // Sideband is forced to zero whenever no beat is offered.
  assign axis_out_tvalid = (state == SEND);
  assign axis_out_tdata  = axis_out_tvalid ? {WORDS{word}} : '0;
  assign axis_out_tlast  = axis_out_tvalid && last_beat;
  assign axis_out_tid    = axis_out_tvalid ? pkt_seq_q[TID_WIDTH-1:0] : '0;
  assign axis_out_tdest  = axis_out_tvalid ? dest_calc : '0;
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign pkts_sent       = pkts_sent_q;

endmodule
